// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - source-select state encodings and mux select constants
package mux_sel_pkg;

    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2
    } src_state_e;

    localparam logic [1:0] SEL_A = 2'b01;
    localparam logic [1:0] SEL_B = 2'b10;
    localparam logic [1:0] SEL_C = 2'b00;

    function automatic logic [1:0] sel_of(input src_state_e s);
        case (s)
            S_B:     sel_of = SEL_B;
            S_C:     sel_of = SEL_C;
            default: sel_of = SEL_A;
        endcase
    endfunction

    function automatic src_state_e next_of(input src_state_e s);
        case (s)
            S_A:     next_of = S_B;
            S_B:     next_of = S_C;
            default: next_of = S_A;
        endcase
    endfunction

    function automatic src_state_e prev_of(input src_state_e s);
        case (s)
            S_A:     prev_of = S_C;
            S_C:     prev_of = S_B;
            default: prev_of = S_A;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stable-level debounce and press pulse for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Only the released->pressed transition is an event.
            deb_d   = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mux_sel_ctrl.sv
// rtl/mux_sel_ctrl.sv - button-driven A/B/C source-select FSM for the output mux
// Optional timed auto-scan enabled by macro MUX_SEL_AUTO_SCAN_EN.
module mux_sel_ctrl
    import mux_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCAN_CYCLES     = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next_n,
    input  logic       btn_prev_n,
    input  logic       hold,
    output logic [1:0] sel,
    output logic       sel_chg,
    output logic [1:0] src_idx
);

    if (DEBOUNCE_CYCLES < 2 || SCAN_CYCLES < 2) begin : g_param_chk
        $error("mux_sel_ctrl: DEBOUNCE_CYCLES and SCAN_CYCLES must be >= 2");
    end

    logic       next_evt;
    logic       prev_evt;

    src_state_e state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] src_idx_q, src_idx_d;
    logic       sel_chg_q, sel_chg_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_next (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_next_n),
        .press (next_evt)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_prev_n),
        .press (prev_evt)
    );

`ifdef MUX_SEL_AUTO_SCAN_EN
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
`ifdef MUX_SEL_AUTO_SCAN_EN
        scan_cnt_d = scan_cnt_q;
`endif
        if (!hold) begin
            if (next_evt && !prev_evt) begin
                state_d = next_of(state_q);
            end else if (prev_evt && !next_evt) begin
                state_d = prev_of(state_q);
            end
`ifdef MUX_SEL_AUTO_SCAN_EN
            // A button event restarts the dwell and overrides a coincident wrap.
            if (next_evt || prev_evt) begin
                scan_cnt_d = '0;
            end else if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                state_d    = next_of(state_q);
            end else begin
                scan_cnt_d = scan_cnt_q + CNT_W'(1);
            end
`endif
        end
        // Outputs register alongside the state so they change on the same edge.
        sel_d     = sel_of(state_d);
        src_idx_d = state_d;
        sel_chg_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            sel_q      <= SEL_A;
            src_idx_q  <= 2'd0;
            sel_chg_q  <= 1'b0;
`ifdef MUX_SEL_AUTO_SCAN_EN
            scan_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            src_idx_q  <= src_idx_d;
            sel_chg_q  <= sel_chg_d;
`ifdef MUX_SEL_AUTO_SCAN_EN
            scan_cnt_q <= scan_cnt_d;
`endif
        end
    end

    assign sel     = sel_q;
    assign sel_chg = sel_chg_q;
    assign src_idx = src_idx_q;

endmodule
